// File: rtl/lc4_ss_pkg.sv
// Shared micro-op type, stall codes and dependence helpers for the two-wide LC4 dispatch stage.
package lc4_ss_pkg;

   typedef struct packed {
      logic [15:0] insn;
      logic [15:0] pc;
      logic [2:0]  rs;
      logic        rs_re;
      logic [2:0]  rt;
      logic        rt_re;
      logic [2:0]  rd;
      logic        rd_we;
      logic        is_load;
      logic        is_store;
      logic        is_ctrl;
   } lc4_uop_t;

   localparam logic [1:0] STALL_NONE  = 2'd0;
   localparam logic [1:0] STALL_EMPTY = 2'd1;
   localparam logic [1:0] STALL_LTU   = 2'd2;
   localparam logic [1:0] STALL_SPLIT = 2'd3;

   // A store's rt is its data operand, which is bypassed later in M, so an rt-only match is not a hazard.
   function automatic logic dep(input lc4_uop_t u, input lc4_uop_t p);
      logic rs_hit;
      logic rt_hit;
      rs_hit = u.rs_re && (u.rs == p.rd);
      rt_hit = u.rt_re && (u.rt == p.rd) && !u.is_store;
      return p.rd_we && (rs_hit || rt_hit);
   endfunction

   function automatic logic is_mem(input lc4_uop_t u);
      return u.is_load || u.is_store;
   endfunction

endpackage

// File: rtl/lc4_ss_hazard.sv
// Combinational issue decision: how many of S0/S1 go to X this cycle, plus per-pipe stall codes.
// Zero latency; a hazard on S0 blocks S1 so issue stays strictly in order.
module lc4_ss_hazard
   import lc4_ss_pkg::*;
(
   input  lc4_uop_t   s0,
   input  logic       s0_vld,
   input  lc4_uop_t   s1,
   input  logic       s1_vld,
   input  lc4_uop_t   x_a,
   input  logic       x_vld_a,
   input  lc4_uop_t   x_b,
   input  logic       x_vld_b,
   output logic [1:0] issue_cnt,
   output logic [1:0] stall_a,
   output logic [1:0] stall_b
);

   logic lu0;
   logic lu1;
   logic split;
   logic unused_fields;

   assign lu0 = (x_vld_a && x_a.is_load && dep(s0, x_a)) ||
                (x_vld_b && x_b.is_load && dep(s0, x_b));
   assign lu1 = (x_vld_a && x_a.is_load && dep(s1, x_a)) ||
                (x_vld_b && x_b.is_load && dep(s1, x_b));

   // Any of these keeps S1 behind; it becomes S0 next cycle and issues down pipe A.
   assign split = !s1_vld || dep(s1, s0) || (is_mem(s0) && is_mem(s1)) ||
                  s0.is_ctrl || lu1;

   always_comb begin
      issue_cnt = 2'd0;
      stall_a   = STALL_NONE;
      stall_b   = STALL_SPLIT;
      if (!s0_vld) begin
         stall_a = STALL_EMPTY;
         stall_b = STALL_EMPTY;
      end else if (lu0) begin
         stall_a = STALL_LTU;
         stall_b = STALL_LTU;
      end else if (split) begin
         issue_cnt = 2'd1;
         if (!s1_vld)
            stall_b = STALL_EMPTY;
         else if (lu1)
            stall_b = STALL_LTU;
         else
            stall_b = STALL_SPLIT;
      end else begin
         issue_cnt = 2'd2;
         stall_b   = STALL_NONE;
      end
   end

   assign unused_fields = ^{s0.insn, s0.pc, s1.insn, s1.pc, s1.rd, s1.rd_we, s1.is_ctrl,
                            x_a.insn, x_a.pc, x_a.rs, x_a.rs_re, x_a.rt, x_a.rt_re,
                            x_a.is_store, x_a.is_ctrl,
                            x_b.insn, x_b.pc, x_b.rs, x_b.rs_re, x_b.rt, x_b.rt_re,
                            x_b.is_store, x_b.is_ctrl};

endmodule

// File: rtl/lc4_ss_dispatch.sv
// Two-wide dispatch: 2-entry in-order buffer feeding the A/B execute latch; fetch->X is two edges.
// Backpressure via o_fd_accept (0-2 uops taken per cycle); gwe=0 freezes everything, flush empties it.
module lc4_ss_dispatch
   import lc4_ss_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       gwe,
   input  logic       i_flush,
   input  logic [1:0] i_fd_valid,
   input  lc4_uop_t   i_fd_uop0,
   input  lc4_uop_t   i_fd_uop1,
   output logic [1:0] o_fd_accept,
   output logic [2:0] o_rs_A,
   output logic [2:0] o_rt_A,
   output logic [2:0] o_rs_B,
   output logic [2:0] o_rt_B,
   output lc4_uop_t   o_x_uop_A,
   output lc4_uop_t   o_x_uop_B,
   output logic       o_x_valid_A,
   output logic       o_x_valid_B,
   output logic [1:0] o_x_stall_A,
   output logic [1:0] o_x_stall_B
);

   lc4_uop_t   s0;
   lc4_uop_t   s1;
   logic       s0_vld;
   logic       s1_vld;

   logic [1:0] issue_cnt;
   logic [1:0] stall_a;
   logic [1:0] stall_b;

   logic [1:0] n_vld;
   logic [1:0] n_surv;
   logic [1:0] n_free;
   logic [1:0] n_fetch;
   logic [1:0] n_take;
   logic [1:0] n_total;
   lc4_uop_t   nxt_s0;
   lc4_uop_t   nxt_s1;

   lc4_ss_hazard u_hazard (
      .s0        (s0),
      .s0_vld    (s0_vld),
      .s1        (s1),
      .s1_vld    (s1_vld),
      .x_a       (o_x_uop_A),
      .x_vld_a   (o_x_valid_A),
      .x_b       (o_x_uop_B),
      .x_vld_b   (o_x_valid_B),
      .issue_cnt (issue_cnt),
      .stall_a   (stall_a),
      .stall_b   (stall_b)
   );

   assign o_rs_A = s0.rs;
   assign o_rt_A = s0.rt;
   assign o_rs_B = s1.rs;
   assign o_rt_B = s1.rt;

   assign n_vld   = {1'b0, s0_vld} + {1'b0, s1_vld};
   assign n_surv  = n_vld - issue_cnt;
   assign n_free  = 2'd2 - n_surv;
   assign n_fetch = {1'b0, i_fd_valid[0]} + {1'b0, i_fd_valid[1]};
   assign n_take  = (n_fetch < n_free) ? n_fetch : n_free;
   assign n_total = n_surv + n_take;

   assign o_fd_accept = (gwe && !i_flush) ? n_take : 2'd0;

   // Survivors keep their order at the front; accepted fetch uops fill in behind them.
   always_comb begin
      nxt_s0 = i_fd_uop0;
      nxt_s1 = i_fd_uop1;
      if (n_surv == 2'd2) begin
         nxt_s0 = s0;
         nxt_s1 = s1;
      end else if (n_surv == 2'd1) begin
         nxt_s0 = (issue_cnt == 2'd0) ? s0 : s1;
         nxt_s1 = i_fd_uop0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0          <= '0;
         s1          <= '0;
         s0_vld      <= 1'b0;
         s1_vld      <= 1'b0;
         o_x_uop_A   <= '0;
         o_x_uop_B   <= '0;
         o_x_valid_A <= 1'b0;
         o_x_valid_B <= 1'b0;
         o_x_stall_A <= STALL_EMPTY;
         o_x_stall_B <= STALL_EMPTY;
      end else if (gwe) begin
         if (i_flush) begin
            s0_vld      <= 1'b0;
            s1_vld      <= 1'b0;
            o_x_uop_A   <= '0;
            o_x_uop_B   <= '0;
            o_x_valid_A <= 1'b0;
            o_x_valid_B <= 1'b0;
            o_x_stall_A <= STALL_SPLIT;
            o_x_stall_B <= STALL_SPLIT;
         end else begin
            s0          <= nxt_s0;
            s1          <= nxt_s1;
            s0_vld      <= (n_total >= 2'd1);
            s1_vld      <= (n_total == 2'd2);
            o_x_uop_A   <= (issue_cnt >= 2'd1) ? s0 : '0;
            o_x_uop_B   <= (issue_cnt == 2'd2) ? s1 : '0;
            o_x_valid_A <= (issue_cnt >= 2'd1);
            o_x_valid_B <= (issue_cnt == 2'd2);
            o_x_stall_A <= stall_a;
            o_x_stall_B <= stall_b;
         end
      end
   end

endmodule

// File: doc/lc4_ss_dispatch.md
# lc4_ss_dispatch

Two-wide decode/dispatch stage of the superscalar LC4 pipeline. It holds a 2-entry in-order buffer of decoded micro-ops from fetch/decode, drives the four register-file read selectors, and decides each cycle whether to issue 0, 1 or 2 micro-ops. Issued micro-ops are registered into the execute (X) latch for pipe A (older) and pipe B (younger). It detects intra-pair dependences, memory-port conflicts and load-use hazards, and handles pipe switching when a pair is split.

## Interface
Parameters:
- none; all widths are fixed by `lc4_ss_pkg`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `gwe`  in  1  global write enable. When 0, no state updates.
- `i_flush`  in  1  X-stage redirect (mispredict). Kills buffer and X latch.
- `i_fd_valid`  in  2  fetch micro-ops valid. Bit 1 set implies bit 0 set.
- `i_fd_uop0`, `i_fd_uop1`  in  `lc4_uop_t`  fetch micro-ops; 0 is older.
- `o_fd_accept`  out  2  count (0–2) of fetch micro-ops consumed this cycle. Combinational.
- `o_rs_A`, `o_rt_A`, `o_rs_B`, `o_rt_B`  out  3 each  register-file read selectors from S0 and S1.
- `o_x_uop_A`, `o_x_uop_B`  out  `lc4_uop_t`  X latch contents. Registered.
- `o_x_valid_A`, `o_x_valid_B`  out  1  X latch valid.
- `o_x_stall_A`, `o_x_stall_B`  out  2  stall reason codes, listed under Operation.

## Operation
- Buffer: S0 (older) and S1, each with a valid bit. S1 valid implies S0 valid.
- Definition: `dep(u, p)` is true when p is a valid write (`p.rd_we`) and either:
  - u reads `p.rd` via rs (`rs_re`), or
  - u reads `p.rd` via rt (`rt_re`), except when u is a store and only rt matches. Store data is bypassed in M.
- Load-use on S0: true if `dep(S0, x)` holds for any valid X-latch uop x with `is_load`.
- Load-use on S1: the same test applied to S1.
- Issue count k:
  - k = 0 if S0 is invalid or S0 has a load-use hazard.
  - Otherwise k = 1 if any of the following holds:
    - S1 is invalid;
    - `dep(S1, S0)`;
    - S0 and S1 are both loads/stores;
    - S0 is control (`is_ctrl`);
    - S1 has a load-use hazard.
  - Otherwise k = 2.
- Issue mapping: S0 goes to pipe A, S1 to pipe B. After k = 1, the old S1 becomes S0 next cycle (pipe switch).
- Free slots after issue: f = 2 − (valid entries − k).
- `o_fd_accept` = min(f, popcount(`i_fd_valid`)). Accepted uops are appended behind the survivors, in order.
- X latch:
  - A receives S0 if k ≥ 1, else a bubble.
  - B receives S1 if k = 2, else a bubble.
  - Bubbles have uop = 0 and valid = 0.
- Pipe A stall codes: 0 issued, 1 empty, 2 load-use, 3 flushed.
- Pipe B stall codes: 0 issued, 1 empty, 2 load-use (on S1 or S0), 3 split/flushed.
- Flush (when `gwe` = 1): buffer cleared, X latch bubbled with both codes = 3, `o_fd_accept` = 0. Flush overrides all issue decisions.
- `gwe` = 0: buffer and X latch hold; `o_fd_accept` = 0.

## Timing
- Reset (async, immediate): S0 and S1 invalid, X latch zero/invalid, both stall codes = 1.
- Read selectors are combinational from the buffer, so register data is valid in the same cycle. Registered uop and register-file data enter X at the same edge.
- Minimum latency fetch → X is 2 edges: accept edge, then issue edge.
- Simultaneous fetch and issue in one cycle is legal: survivors shift and new uops fill in a single edge.
- A hazard on S0 blocks S1 regardless of S1's own hazards. Issue is strictly in order.

## Structure
- `lc4_ss_pkg` holds:
  - `lc4_uop_t` packed struct: `insn[15:0]`, `pc[15:0]`, `rs`, `rs_re`, `rt`, `rt_re`, `rd`, `rd_we`, `is_load`, `is_store`, `is_ctrl`.
  - Stall-code localparams `STALL_NONE` = 0, `STALL_EMPTY` = 1, `STALL_LTU` = 2, `STALL_SPLIT` = 3.
  - A `dep()` function.
- One sub-module, `lc4_ss_hazard`: purely combinational; computes k and the stall codes from S0, S1 and the X latch. Buffer and latch registers stay in the top module.

## Test plan
- Reset mid-stream: assert `rst` with the buffer full → same cycle, both X valid = 0, stall codes 1/1, `o_fd_accept` = 2 on the next cycle with fetch valid = 2'b11.
- Independent pair (ADD R1,R2,R3; ADD R4,R5,R6) → k = 2, `o_fd_accept` = 2, next edge A = ADD R1, B = ADD R4, codes 0/0.
- Dependent pair (ADD R1,…; ADD R2,R1,R3) → A issues, B code 3. Next cycle the second ADD is issued in pipe A.
- Load-use: LDR R1 in X-A, S0 = ADD R2,R1,R1 → k = 0, codes 2/2. Next cycle issues.
- Store data exemption: LDR R1 in X-A, S0 = STR R1,R2,#0 (rt = R1) → no stall, k ≥ 1.
- Flush with full buffer and fetch valid = 2'b11 → next edge X invalid, codes 3/3, buffer empty, `o_fd_accept` = 0 in the flush cycle.
